// File: rtl/sccb_master_ctrl.sv
// SCCB master: single register write (3-phase) or read (2-phase) per command,
// accepted over a valid/ready handshake. All outputs registered.
module sccb_master_ctrl #(
   parameter int unsigned CLK_DIV    = 125,
   parameter logic [7:0]  SLAVE_ID   = 8'h42,
   parameter int unsigned ADDR_W     = 8,
   parameter bit          IGNORE_ACK = 1'b1
) (
   input  logic              PCLK,
   input  logic              PRESETN,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rd,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [7:0]        cmd_wdata,
   output logic              rsp_valid,
   output logic [7:0]        rsp_rdata,
   output logic              rsp_nack,
   output logic              busy,
   output logic              sioc,
   output logic              siod_o,
   output logic              siod_o_en,
   input  logic              siod_i
);

   localparam int unsigned   NB     = ADDR_W / 8;
   localparam int unsigned   QW     = $clog2(CLK_DIV);
   localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_BYTE, S_STOP, S_GAP, S_DONE} state_t;

   state_t        state, nxt_state;
   logic [QW-1:0] q_cnt, nxt_q_cnt;
   logic [1:0]    qtr, nxt_qtr;
   logic [1:0]    byte_idx, nxt_byte_idx, last_idx;
   logic [2:0]    bit_cnt, nxt_bit_cnt;
   logic          ack_bit, nxt_ack_bit;
   logic          phase2, nxt_phase2;
   logic          rd_r;
   logic [15:0]   addr_r;
   logic [7:0]    wdata_r, rx_sr, tx_byte;
   logic          accept, q_end, rx_byte_now, rx_byte_nxt;
   logic          nxt_sioc, nxt_siod, nxt_en;

   always_comb begin
      accept       = cmd_valid && cmd_ready;
      q_end        = (q_cnt == Q_LAST);
      last_idx     = phase2 ? 2'd1 : (rd_r ? 2'(NB) : 2'(NB + 1));
      rx_byte_now  = phase2 && (byte_idx == 2'd1);
      nxt_state    = state;
      nxt_q_cnt    = q_end ? '0 : q_cnt + 1'b1;
      nxt_qtr      = qtr;
      nxt_byte_idx = byte_idx;
      nxt_bit_cnt  = bit_cnt;
      nxt_ack_bit  = ack_bit;
      nxt_phase2   = phase2;
      case (state)
         S_IDLE: begin
            nxt_q_cnt = '0;
            if (accept) begin
               nxt_state    = S_START;
               nxt_qtr      = '0;
               nxt_byte_idx = '0;
               nxt_bit_cnt  = '0;
               nxt_ack_bit  = 1'b0;
               nxt_phase2   = 1'b0;
            end
         end
         S_DONE: begin
            nxt_state = S_IDLE;
            nxt_q_cnt = '0;
         end
         default: begin
            if (q_end) begin
               nxt_qtr = qtr + 2'd1;
               if (qtr == 2'd3) begin
                  case (state)
                     S_START: begin
                        nxt_state   = S_BYTE;
                        nxt_bit_cnt = '0;
                        nxt_ack_bit = 1'b0;
                     end
                     S_BYTE: begin
                        if (!ack_bit) begin
                           if (bit_cnt == 3'd7) nxt_ack_bit = 1'b1;
                           else                 nxt_bit_cnt = bit_cnt + 3'd1;
                        end else begin
                           nxt_ack_bit = 1'b0;
                           nxt_bit_cnt = '0;
                           if (byte_idx == last_idx) nxt_state    = S_STOP;
                           else                      nxt_byte_idx = byte_idx + 2'd1;
                        end
                     end
                     S_STOP: nxt_state = (rd_r && !phase2) ? S_GAP : S_DONE;
                     S_GAP: begin
                        nxt_state    = S_START;
                        nxt_phase2   = 1'b1;
                        nxt_byte_idx = '0;
                     end
                     default: ;
                  endcase
               end
            end
         end
      endcase

      // Bus levels are decoded from the next position so they appear in the
      // same cycle the FSM enters that quarter.
      rx_byte_nxt = nxt_phase2 && (nxt_byte_idx == 2'd1);
      tx_byte     = wdata_r;
      if (nxt_byte_idx == 2'd0)
         tx_byte = nxt_phase2 ? (SLAVE_ID | 8'h01) : SLAVE_ID;
      else if (nxt_byte_idx <= 2'(NB))
         tx_byte = (NB == 2 && nxt_byte_idx == 2'd1) ? addr_r[15:8] : addr_r[7:0];

      nxt_sioc = 1'b1;
      nxt_siod = 1'b1;
      nxt_en   = 1'b0;
      case (nxt_state)
         S_START: begin
            nxt_en   = 1'b1;
            nxt_siod = (nxt_qtr == 2'd0);
         end
         S_STOP: begin
            nxt_en   = 1'b1;
            nxt_sioc = (nxt_qtr != 2'd0);
            nxt_siod = nxt_qtr[1];
         end
         S_GAP: nxt_en = 1'b1;
         S_BYTE: begin
            nxt_sioc = nxt_qtr[1];
            if (nxt_ack_bit) begin
               nxt_en = rx_byte_nxt;
            end else if (!rx_byte_nxt) begin
               nxt_en   = 1'b1;
               nxt_siod = tx_byte[~nxt_bit_cnt];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state     <= S_IDLE;
         q_cnt     <= '0;
         qtr       <= '0;
         byte_idx  <= '0;
         bit_cnt   <= '0;
         ack_bit   <= 1'b0;
         phase2    <= 1'b0;
         rd_r      <= 1'b0;
         addr_r    <= '0;
         wdata_r   <= '0;
         rx_sr     <= '0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_nack  <= 1'b0;
         sioc      <= 1'b1;
         siod_o    <= 1'b1;
         siod_o_en <= 1'b0;
      end else begin
         state     <= nxt_state;
         q_cnt     <= nxt_q_cnt;
         qtr       <= nxt_qtr;
         byte_idx  <= nxt_byte_idx;
         bit_cnt   <= nxt_bit_cnt;
         ack_bit   <= nxt_ack_bit;
         phase2    <= nxt_phase2;
         sioc      <= nxt_sioc;
         siod_o    <= nxt_siod;
         siod_o_en <= nxt_en;
         rsp_valid <= (nxt_state == S_DONE);
         if (accept) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            rd_r      <= cmd_rd;
            addr_r    <= 16'(cmd_addr);
            wdata_r   <= cmd_wdata;
            rsp_nack  <= 1'b0;
         end else if (state == S_DONE) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
         end
         if (state == S_BYTE && qtr == 2'd2 && q_end) begin
            if (ack_bit && !rx_byte_now) begin
               if (!IGNORE_ACK && siod_i) rsp_nack <= 1'b1;
            end else if (!ack_bit && rx_byte_now) begin
               rx_sr <= {rx_sr[6:0], siod_i};
            end
         end
         if (state == S_STOP && nxt_state == S_DONE && rd_r)
            rsp_rdata <= rx_sr;
      end
   end

endmodule

// File: tb/tb_sccb_master_ctrl.sv
// Directed bench for sccb_master_ctrl: an 8-bit/ACK-checked instance and a
// 16-bit/ACK-ignored instance share one bus monitor and slave model.
module tb_sccb_master_ctrl;

   logic PCLK = 1'b0;
   logic PRESETN = 1'b0;
   always #5 PCLK = ~PCLK;

   logic       a_valid, a_ready, a_rd, a_rsp_valid, a_nack, a_busy;
   logic       a_sioc, a_siod_o, a_en, a_siod_i;
   logic [7:0] a_addr, a_wdata, a_rdata;

   logic        b_valid, b_ready, b_rd, b_rsp_valid, b_nack, b_busy;
   logic        b_sioc, b_siod_o, b_en, b_siod_i;
   logic [15:0] b_addr;
   logic [7:0]  b_wdata, b_rdata;

   sccb_master_ctrl #(.CLK_DIV(4), .SLAVE_ID(8'h42), .ADDR_W(8), .IGNORE_ACK(1'b0)) u_dut_a (
      .PCLK(PCLK), .PRESETN(PRESETN), .cmd_valid(a_valid), .cmd_ready(a_ready),
      .cmd_rd(a_rd), .cmd_addr(a_addr), .cmd_wdata(a_wdata), .rsp_valid(a_rsp_valid),
      .rsp_rdata(a_rdata), .rsp_nack(a_nack), .busy(a_busy), .sioc(a_sioc),
      .siod_o(a_siod_o), .siod_o_en(a_en), .siod_i(a_siod_i)
   );

   sccb_master_ctrl #(.CLK_DIV(4), .SLAVE_ID(8'h42), .ADDR_W(16), .IGNORE_ACK(1'b1)) u_dut_b (
      .PCLK(PCLK), .PRESETN(PRESETN), .cmd_valid(b_valid), .cmd_ready(b_ready),
      .cmd_rd(b_rd), .cmd_addr(b_addr), .cmd_wdata(b_wdata), .rsp_valid(b_rsp_valid),
      .rsp_rdata(b_rdata), .rsp_nack(b_nack), .busy(b_busy), .sioc(b_sioc),
      .siod_o(b_siod_o), .siod_o_en(b_en), .siod_i(b_siod_i)
   );

   // Slave model and monitor act on whichever instance 'sel' points at.
   logic       sel = 1'b0;
   logic       nack_mode = 1'b0;
   logic [7:0] rd_val = 8'h00;
   logic       s_oe = 1'b0;
   logic       s_val = 1'b0;

   assign a_siod_i = a_en ? a_siod_o : ((!sel && s_oe) ? s_val : 1'b1);
   assign b_siod_i = b_en ? b_siod_o : ((sel && s_oe) ? s_val : 1'b1);

   logic        m_c, m_d;
   assign m_c = sel ? b_sioc : a_sioc;
   assign m_d = sel ? b_siod_i : a_siod_i;

   logic [7:0]  mon_q[$];
   logic        ack_q[$];
   int unsigned n_start = 0;
   int unsigned n_stop = 0;
   logic        prev_c = 1'b1;
   logic        prev_d = 1'b1;
   int unsigned bitn = 0;
   int unsigned byte_n = 0;
   logic        rd_mode = 1'b0;
   logic        rx;
   logic [7:0]  sh = 8'h00;
   logic [2:0]  bi;

   always @(negedge PCLK) begin
      if (!PRESETN) begin
         bitn = 0; byte_n = 0; rd_mode = 1'b0; s_oe = 1'b0;
         prev_c = 1'b1; prev_d = 1'b1;
      end else begin
         if (prev_c && m_c && prev_d && !m_d) begin
            n_start++; bitn = 0; byte_n = 0; rd_mode = 1'b0;
         end else if (prev_c && m_c && !prev_d && m_d) begin
            n_stop++;
         end else if (!prev_c && m_c) begin
            if (bitn < 8) begin
               sh = {sh[6:0], m_d};
               bitn++;
            end else begin
               ack_q.push_back(m_d);
               mon_q.push_back(sh);
               if (byte_n == 0) rd_mode = sh[0];
               byte_n++;
               bitn = 0;
            end
         end else if (prev_c && !m_c) begin
            rx = rd_mode && (byte_n == 1);
            if (bitn == 8) begin
               s_oe = !rx && !nack_mode;
               s_val = 1'b0;
            end else if (rx) begin
               bi = 3'(7 - bitn);
               s_oe = 1'b1;
               s_val = rd_val[bi];
            end else begin
               s_oe = 1'b0;
            end
         end
         prev_c = m_c;
         prev_d = m_d;
      end
   end

   int unsigned n_checks = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] qb(input int unsigned i);
      return (i < mon_q.size()) ? mon_q[i] : 8'hxx;
   endfunction

   function automatic logic qa(input int unsigned i);
      return (i < ack_q.size()) ? ack_q[i] : 1'bx;
   endfunction

   task automatic run_cmd(input logic s, input logic rd, input logic [15:0] addr,
                          input logic [7:0] wd, output int unsigned lat);
      int unsigned n;
      n = 0;
      @(negedge PCLK);
      while (!(s ? b_ready : a_ready) && n < 100) begin
         @(negedge PCLK);
         n++;
      end
      if (s) begin b_rd = rd; b_addr = addr; b_wdata = wd; b_valid = 1'b1; end
      else   begin a_rd = rd; a_addr = addr[7:0]; a_wdata = wd; a_valid = 1'b1; end
      @(posedge PCLK);
      @(negedge PCLK);
      a_valid = 1'b0;
      b_valid = 1'b0;
      lat = 1;
      while (!(s ? b_rsp_valid : a_rsp_valid) && lat < 3000) begin
         @(negedge PCLK);
         lat++;
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   int unsigned lat, base, st0, sp0, k;

   initial begin
      a_valid = 1'b0; a_rd = 1'b0; a_addr = '0; a_wdata = '0;
      b_valid = 1'b0; b_rd = 1'b0; b_addr = '0; b_wdata = '0;
      repeat (3) @(negedge PCLK);
      PRESETN = 1'b1;
      @(negedge PCLK);

      check("rst_bus_a", {a_sioc, a_siod_o, a_en}, 3'b110);
      check("rst_hs_a", {a_ready, a_busy, a_rsp_valid, a_nack}, 4'b1000);
      check("rst_rdata_a", a_rdata, 8'h00);
      check("rst_bus_b", {b_sioc, b_siod_o, b_en, b_ready, b_busy}, 5'b11010);

      // Write 0x12 <- 0x80
      base = mon_q.size(); sp0 = n_stop;
      run_cmd(1'b0, 1'b0, 16'h0012, 8'h80, lat);
      check("wr_lat", lat, 465);
      check("wr_nbytes", mon_q.size() - base, 3);
      check("wr_b0", qb(base), 8'h42);
      check("wr_b1", qb(base + 1), 8'h12);
      check("wr_b2", qb(base + 2), 8'h80);
      check("wr_acks", {qa(base), qa(base + 1), qa(base + 2)}, 3'b000);
      check("wr_nack", a_nack, 1'b0);
      check("wr_stops", n_stop - sp0, 1);

      // Read 0x0A, slave returns 0x76
      rd_val = 8'h76;
      base = mon_q.size(); sp0 = n_stop; st0 = n_start;
      run_cmd(1'b0, 1'b1, 16'h000A, 8'h00, lat);
      check("rd_lat", lat, 657);
      check("rd_nbytes", mon_q.size() - base, 4);
      check("rd_b0", qb(base), 8'h42);
      check("rd_b1", qb(base + 1), 8'h0A);
      check("rd_b2", qb(base + 2), 8'h43);
      check("rd_b3", qb(base + 3), 8'h76);
      check("rd_na", qa(base + 3), 1'b1);
      check("rd_rdata", a_rdata, 8'h76);
      check("rd_nack", a_nack, 1'b0);
      check("rd_starts", n_start - st0, 2);
      check("rd_stops", n_stop - sp0, 2);

      // 16-bit sub-address write 0x3008 <- 0x82
      sel = 1'b1;
      base = mon_q.size();
      run_cmd(1'b1, 1'b0, 16'h3008, 8'h82, lat);
      check("w16_lat", lat, 609);
      check("w16_nbytes", mon_q.size() - base, 4);
      check("w16_b0", qb(base), 8'h42);
      check("w16_b1", qb(base + 1), 8'h30);
      check("w16_b2", qb(base + 2), 8'h08);
      check("w16_b3", qb(base + 3), 8'h82);

      // Slave never acknowledges
      nack_mode = 1'b1;
      sel = 1'b0;
      run_cmd(1'b0, 1'b0, 16'h0012, 8'h80, lat);
      check("nack_lat", lat, 465);
      check("nack_set", a_nack, 1'b1);
      check("rdata_hold", a_rdata, 8'h76);
      sel = 1'b1;
      run_cmd(1'b1, 1'b0, 16'h3008, 8'h82, lat);
      check("nack_ignored", b_nack, 1'b0);
      sel = 1'b0;
      nack_mode = 1'b0;

      // Back-to-back with cmd_valid held, then a pulse while busy
      base = mon_q.size();
      @(negedge PCLK);
      a_rd = 1'b0; a_addr = 8'h12; a_wdata = 8'h80; a_valid = 1'b1;
      k = 0;
      while (!a_rsp_valid && k < 3000) begin
         @(negedge PCLK);
         k++;
      end
      check("hs_first_done", a_rsp_valid, 1'b1);
      k = 0;
      do begin
         @(negedge PCLK);
         k++;
      end while (!a_busy && k < 10);
      check("hs_gap", k, 2);
      check("hs_nack_clr", a_nack, 1'b0);
      a_valid = 1'b0;
      lat = 1;
      repeat (49) @(negedge PCLK);
      lat += 49;
      a_rd = 1'b1; a_valid = 1'b1;
      @(negedge PCLK);
      lat++;
      a_valid = 1'b0; a_rd = 1'b0;
      while (!a_rsp_valid && lat < 3000) begin
         @(negedge PCLK);
         lat++;
      end
      check("hs_lat2", lat, 465);
      check("hs_nbytes", mon_q.size() - base, 6);
      check("hs_b3", qb(base + 3), 8'h42);
      check("hs_b5", qb(base + 5), 8'h80);
      k = 0;
      repeat (10) begin
         @(negedge PCLK);
         if (a_busy) k++;
      end
      check("busy_pulse_ignored", k, 0);

      // Reset in the middle of the sub-address byte
      @(negedge PCLK);
      a_rd = 1'b0; a_addr = 8'h55; a_wdata = 8'hA5; a_valid = 1'b1;
      @(negedge PCLK);
      a_valid = 1'b0;
      repeat (200) @(negedge PCLK);
      check("mid_busy", a_busy, 1'b1);
      PRESETN = 1'b0;
      #1;
      check("mid_rst_bus", {a_sioc, a_en}, 2'b10);
      check("mid_rst_hs", {a_busy, a_ready, a_rsp_valid}, 3'b010);
      repeat (2) @(negedge PCLK);
      PRESETN = 1'b1;
      base = mon_q.size();
      run_cmd(1'b0, 1'b0, 16'h0055, 8'hA5, lat);
      check("post_rst_lat", lat, 465);
      check("post_rst_nbytes", mon_q.size() - base, 3);
      check("post_rst_b1", qb(base + 1), 8'h55);
      check("post_rst_b2", qb(base + 2), 8'hA5);
      check("post_rst_nack", a_nack, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
